// File: rtl/can_phy_frontend.sv
// CAN pin-side conditioning: RX synchroniser and deglitcher, bus integration,
// idle detection and stuck-dominant guards on both RX and TX directions.
module can_phy_frontend #(
  parameter int FILTER_LEN      = 3,
  parameter int BIT_CLKS        = 100,
  parameter int IDLE_BITS       = 11,
  parameter int STUCK_BITS      = 32,
  parameter int TX_TIMEOUT_BITS = 32
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       phy_rx,
  output logic       phy_tx,
  input  logic       core_tx,
  output logic       core_rx,
  input  logic       fault_clr,
  output logic       bus_idle,
  output logic       rx_fault,
  output logic       tx_fault,
  output logic [1:0] state_o
);

  localparam int IDLE_LIM  = IDLE_BITS * BIT_CLKS;
  localparam int STUCK_LIM = STUCK_BITS * BIT_CLKS;
  localparam int TX_LIM    = TX_TIMEOUT_BITS * BIT_CLKS;
  localparam int IDLE_W    = $clog2(IDLE_LIM + 1);
  localparam int STUCK_W   = $clog2(STUCK_LIM + 1);
  localparam int TX_W      = $clog2(TX_LIM + 1);
  localparam int FILT_W    = 4;

  localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_LIM[IDLE_W-1:0];
  localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_LIM[STUCK_W-1:0];
  localparam logic [TX_W-1:0]    TX_MAX    = TX_LIM[TX_W-1:0];
  localparam logic [FILT_W-1:0]  FILT_LAST = FILT_W'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2,
    S_BAD   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [1:0]         rx_sync_reg;
  logic               rx_s;
  logic               filt_reg, filt_next;
  logic [FILT_W-1:0]  filt_cnt_reg, filt_cnt_next;
  logic [IDLE_W-1:0]  rec_cnt_reg, rec_cnt_next;
  logic [STUCK_W-1:0] dom_cnt_reg, dom_cnt_next;
  logic [TX_W-1:0]    tx_cnt_reg, tx_cnt_next;
  logic               bus_idle_reg, bus_idle_next;
  logic               rx_fault_reg, rx_fault_next;
  logic               tx_fault_reg, tx_fault_next;
  logic               core_rx_reg, core_rx_next;
  logic               phy_tx_reg, phy_tx_next;
  logic               rx_lim, tx_lim;

  assign rx_s = rx_sync_reg[1];

  // Filter: filtered level flips only after FILTER_LEN consecutive differing samples
  always_comb begin
    filt_next     = filt_reg;
    filt_cnt_next = '0;
    if (rx_s != filt_reg) begin
      if (filt_cnt_reg == FILT_LAST) begin
        filt_next = rx_s;
      end else begin
        filt_cnt_next = filt_cnt_reg + FILT_W'(1);
      end
    end
  end

  // Saturating run-length counters; they run in every state
  always_comb begin
    rec_cnt_next = '0;
    dom_cnt_next = '0;
    tx_cnt_next  = '0;
    if (filt_reg) begin
      rec_cnt_next = (rec_cnt_reg == IDLE_MAX) ? rec_cnt_reg : rec_cnt_reg + IDLE_W'(1);
    end else begin
      dom_cnt_next = (dom_cnt_reg == STUCK_MAX) ? dom_cnt_reg : dom_cnt_reg + STUCK_W'(1);
    end
    if (!core_tx) begin
      tx_cnt_next = (tx_cnt_reg == TX_MAX) ? tx_cnt_reg : tx_cnt_reg + TX_W'(1);
    end
    bus_idle_next = (rec_cnt_next == IDLE_MAX);
  end

  assign rx_lim = (dom_cnt_reg == STUCK_MAX);
  assign tx_lim = (tx_cnt_reg == TX_MAX);

  always_comb begin
    state_next    = state_reg;
    rx_fault_next = rx_fault_reg;
    tx_fault_next = tx_fault_reg;
    case (state_reg)
      S_INIT: begin
        if (bus_idle_reg) state_next = S_RUN;
      end
      S_RUN: begin
        if (rx_lim) rx_fault_next = 1'b1;
        if (tx_lim) tx_fault_next = 1'b1;
        if (rx_lim || tx_lim) state_next = S_FAULT;
      end
      S_FAULT: begin
        if (fault_clr) begin
          rx_fault_next = 1'b0;
          tx_fault_next = 1'b0;
          state_next    = S_INIT;
        end
      end
      default: state_next = S_INIT;
    endcase
    // Keyed on the next state so a fault forces recessive on the same edge it is flagged
    core_rx_next = (state_next == S_RUN) ? filt_reg : 1'b1;
    phy_tx_next  = (state_next == S_RUN) ? core_tx  : 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_sync_reg  <= 2'b11;
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
      rec_cnt_reg  <= '0;
      dom_cnt_reg  <= '0;
      tx_cnt_reg   <= '0;
      bus_idle_reg <= 1'b0;
      rx_fault_reg <= 1'b0;
      tx_fault_reg <= 1'b0;
      core_rx_reg  <= 1'b1;
      phy_tx_reg   <= 1'b1;
      state_reg    <= S_INIT;
    end else begin
      rx_sync_reg  <= {rx_sync_reg[0], phy_rx};
      filt_reg     <= filt_next;
      filt_cnt_reg <= filt_cnt_next;
      rec_cnt_reg  <= rec_cnt_next;
      dom_cnt_reg  <= dom_cnt_next;
      tx_cnt_reg   <= tx_cnt_next;
      bus_idle_reg <= bus_idle_next;
      rx_fault_reg <= rx_fault_next;
      tx_fault_reg <= tx_fault_next;
      core_rx_reg  <= core_rx_next;
      phy_tx_reg   <= phy_tx_next;
      state_reg    <= state_next;
    end
  end

  assign phy_tx   = phy_tx_reg;
  assign core_rx  = core_rx_reg;
  assign bus_idle = bus_idle_reg;
  assign rx_fault = rx_fault_reg;
  assign tx_fault = tx_fault_reg;
  assign state_o  = state_reg;

endmodule

// File: tb/tb_can_phy_frontend.sv
// Bench for can_phy_frontend: directed scenarios plus random pulse traffic,
// every cycle compared against a behavioural model of the pin conditioning rules.
module tb_can_phy_frontend;

  localparam int FILTER_LEN = 3;
  localparam int IDLE_LIM   = 11 * 100;
  localparam int STUCK_LIM  = 32 * 100;
  localparam int TX_LIM     = 32 * 100;
  localparam int SYNC_LAT   = 2;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic       phy_rx;
  logic       core_tx;
  logic       fault_clr;
  logic       phy_tx;
  logic       core_rx;
  logic       bus_idle;
  logic       rx_fault;
  logic       tx_fault;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_clk = ~clk_clk;

  can_phy_frontend #(
    .FILTER_LEN(FILTER_LEN), .BIT_CLKS(100), .IDLE_BITS(11),
    .STUCK_BITS(32), .TX_TIMEOUT_BITS(32)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .phy_rx(phy_rx),
    .phy_tx(phy_tx), .core_tx(core_tx), .core_rx(core_rx),
    .fault_clr(fault_clr), .bus_idle(bus_idle), .rx_fault(rx_fault),
    .tx_fault(tx_fault), .state_o(state_o)
  );

  // Reference model: pin history, recessive/dominant run lengths, mode and flags
  int m_pin_q[$];
  int m_win[$];
  int m_filt, m_rec, m_dom, m_tx, m_idle, m_rxf, m_txf, m_state, m_core_rx, m_phy_tx;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_pin_q = {};
    repeat (SYNC_LAT) m_pin_q.push_back(1);
    m_win = {};
    repeat (FILTER_LEN) m_win.push_back(1);
    m_filt = 1; m_rec = 0; m_dom = 0; m_tx = 0; m_idle = 0;
    m_rxf = 0; m_txf = 0; m_state = 0; m_core_rx = 1; m_phy_tx = 1;
  endtask

  task automatic model_step();
    int rxs;
    int nxt;
    int all_diff;
    int old_filt;
    old_filt = m_filt;
    nxt = m_state;
    case (m_state)
      0: if (m_idle != 0) nxt = 1;
      1: begin
        if (m_dom >= STUCK_LIM) m_rxf = 1;
        if (m_tx >= TX_LIM) m_txf = 1;
        if (m_rxf != 0 || m_txf != 0) nxt = 2;
      end
      2: if (fault_clr) begin
        nxt = 0; m_rxf = 0; m_txf = 0;
      end
      default: nxt = 0;
    endcase
    m_state   = nxt;
    m_core_rx = (nxt == 1) ? old_filt : 1;
    m_phy_tx  = (nxt == 1) ? int'(core_tx) : 1;
    m_rec  = (old_filt == 1) ? ((m_rec < IDLE_LIM) ? m_rec + 1 : m_rec) : 0;
    m_idle = (m_rec == IDLE_LIM) ? 1 : 0;
    m_dom  = (old_filt == 0) ? ((m_dom < STUCK_LIM) ? m_dom + 1 : m_dom) : 0;
    m_tx   = (core_tx == 1'b0) ? ((m_tx < TX_LIM) ? m_tx + 1 : m_tx) : 0;
    rxs = m_pin_q.pop_front();
    m_pin_q.push_back(int'(phy_rx));
    void'(m_win.pop_front());
    m_win.push_back(rxs);
    all_diff = 1;
    foreach (m_win[i]) if (m_win[i] == m_filt) all_diff = 0;
    if (all_diff == 1) m_filt = 1 - m_filt;
  endtask

  task automatic cycle();
    logic [6:0] exp_vec;
    @(posedge clk_clk);
    model_step();
    @(negedge clk_clk);
    exp_vec = {2'(m_state), 1'(m_core_rx), 1'(m_phy_tx), 1'(m_idle), 1'(m_rxf), 1'(m_txf)};
    check("outputs{state,core_rx,phy_tx,idle,rxf,txf}",
          {state_o, core_rx, phy_tx, bus_idle, rx_fault, tx_fault}, exp_vec);
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo_len, gap, tx_len;
    reset_reset_n = 1'b0; phy_rx = 1'b1; core_tx = 1'b1; fault_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_clk);
    check("reset_state", {state_o, core_rx, phy_tx, bus_idle, rx_fault, tx_fault}, 7'b00_1_1_000);
    reset_reset_n = 1'b1;

    // Integration after reset
    run(IDLE_LIM - 1);
    check("idle_early", bus_idle, 0);
    cycle();
    check("idle_rise", bus_idle, 1);
    check("still_init", state_o, 0);
    cycle();
    check("run_entry", state_o, 1);
    $display("txn integration: bus_idle=%0b state=%0d", bus_idle, state_o);

    // Glitch filter boundary: 2-clk low is rejected, 3-clk low passes
    phy_rx = 1'b0; run(2); phy_rx = 1'b1; run(8);
    check("glitch2_core_rx", core_rx, 1);
    check("glitch2_idle", bus_idle, 1);
    phy_rx = 1'b0; run(3); phy_rx = 1'b1; run(2);
    check("pulse3_pre", core_rx, 1);
    cycle();
    check("pulse3_edge", core_rx, 0);
    check("pulse3_idle_drop", bus_idle, 0);
    run(IDLE_LIM + 20);
    $display("txn glitch: core_rx=%0b bus_idle=%0b", core_rx, bus_idle);

    // Random short pulses on both directions, below fault limits
    for (int t = 0; t < 40; t++) begin
      lo_len = $urandom_range(1, 8);
      gap    = $urandom_range(5, 40);
      tx_len = $urandom_range(0, 30);
      phy_rx = 1'b0;
      core_tx = (tx_len > 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < lo_len + tx_len; c++) begin
        if (c == lo_len) phy_rx = 1'b1;
        if (c == tx_len) core_tx = 1'b1;
        cycle();
      end
      phy_rx = 1'b1; core_tx = 1'b1;
      run(gap);
      $display("txn rand %0d: rx_low=%0d tx_low=%0d gap=%0d state=%0d", t, lo_len, tx_len, gap, state_o);
    end
    run(IDLE_LIM + 20);

    // RX stuck dominant
    phy_rx = 1'b0;
    run(SYNC_LAT + FILTER_LEN + STUCK_LIM);
    check("rx_pre_fault", state_o, 1);
    cycle();
    check("rx_fault_set", rx_fault, 1);
    check("rx_fault_state", state_o, 2);
    check("rx_fault_core_rx", core_rx, 1);
    pulse_clr();
    check("rx_clr_flag", rx_fault, 0);
    check("rx_clr_state", state_o, 0);
    run(50);
    check("rx_clr_core_rx", core_rx, 1);
    phy_rx = 1'b1;
    run(SYNC_LAT + FILTER_LEN + IDLE_LIM);
    check("reinit_wait", state_o, 0);
    check("reinit_idle", bus_idle, 1);
    cycle();
    check("reinit_run", state_o, 1);
    $display("txn rx_stuck: recovered state=%0d", state_o);

    // TX dominant timeout
    core_tx = 1'b0;
    run(TX_LIM);
    check("tx_low_follow", phy_tx, 0);
    cycle();
    check("tx_fault_set", tx_fault, 1);
    check("tx_fault_phy_tx", phy_tx, 1);
    core_tx = 1'b1;
    run(10);
    check("tx_sticky", tx_fault, 1);
    pulse_clr();
    run(5);
    check("tx_recover", state_o, 1);
    $display("txn tx_timeout: tx_fault=%0b state=%0d", tx_fault, state_o);

    // Both limits on the same edge, with fault_clr arriving in S_RUN
    phy_rx = 1'b0;
    run(SYNC_LAT + FILTER_LEN);
    core_tx = 1'b0;
    run(STUCK_LIM);
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    check("both_rx", rx_fault, 1);
    check("both_tx", tx_fault, 1);
    check("both_state", state_o, 2);
    phy_rx = 1'b1; core_tx = 1'b1;
    run(10);
    pulse_clr();
    run(IDLE_LIM + 20);
    $display("txn dual_fault: state=%0d", state_o);

    // Asynchronous reset mid-frame
    core_tx = 1'b0;
    run(10);
    check("pre_reset_phy_tx", phy_tx, 0);
    #2 reset_reset_n = 1'b0;
    #1;
    check("async_phy_tx", phy_tx, 1);
    check("async_core_rx", core_rx, 1);
    check("async_flags", {rx_fault, tx_fault, bus_idle}, 3'b000);
    check("async_state", state_o, 0);
    model_reset();
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    run(20);
    $display("txn async_reset: phy_tx=%0b state=%0d", phy_tx, state_o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
